// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus between fetch and imem
interface fetch_stage_if #(
  parameter int ARCH_LEN = 32,
  parameter int INST_LEN = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ARCH_LEN-1:0] imem_req_addr;
  logic                imem_rsp_valid;
  logic [INST_LEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with one-entry skid buffer and redirect
module fetch_stage #(
  parameter int                  ARCH_LEN = 32,
  parameter int                  INST_LEN = 32,
  parameter logic [ARCH_LEN-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ARCH_LEN-1:0] branch_target,
  fetch_stage_if.master       imem,
  output logic [INST_LEN:0]   inst_fetched_out,
  output logic [ARCH_LEN-1:0] pc_out
);

  typedef struct packed {
    logic                valid;
    logic [INST_LEN-1:0] inst;
  } inst_fetched_t;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ARCH_LEN-1:0] fetch_pc;
  logic [ARCH_LEN-1:0] req_pc;
  logic [ARCH_LEN-1:0] pc_q;
  logic [ARCH_LEN-1:0] skid_pc;
  inst_fetched_t       out_q;
  inst_fetched_t       skid_q;
  logic                req_valid;
  logic                accept;
  logic                rsp_live;
  logic [ARCH_LEN-1:0] redirect_pc;
  logic                unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target[1:0];
  assign redirect_pc        = {branch_target[ARCH_LEN-1:2], 2'b00};
  assign accept             = req_valid && imem.imem_req_ready;
  // Only a response in WAIT belongs to the live request; in DRAIN it is stale, in REQ it is spurious.
  assign rsp_live           = (state == S_WAIT) && imem.imem_rsp_valid;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc;
  assign inst_fetched_out    = out_q;
  assign pc_out              = pc_q;

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    case (state)
      S_REQ: begin
        req_valid = !skid_q.valid && !rst;
        if (req_valid && imem.imem_req_ready) begin
          state_nxt = branch_taken ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_nxt = S_REQ;
        end else if (branch_taken) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem.imem_rsp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      out_q    <= '0;
      pc_q     <= '0;
      skid_q   <= '0;
      skid_pc  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_pc <= fetch_pc;
      end
      if (branch_taken) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + ARCH_LEN'(4);
      end

      if (branch_taken) begin
        out_q.valid  <= 1'b0;
        skid_q.valid <= 1'b0;
      end else if (!stall) begin
        if (skid_q.valid) begin
          out_q        <= skid_q;
          pc_q         <= skid_pc;
          skid_q.valid <= 1'b0;
        end else if (rsp_live) begin
          out_q <= {1'b1, imem.imem_rsp_data};
          pc_q  <= req_pc + ARCH_LEN'(4);
        end else begin
          out_q.valid <= 1'b0;
        end
      end else if (!out_q.valid) begin
        if (rsp_live) begin
          out_q <= {1'b1, imem.imem_rsp_data};
          pc_q  <= req_pc + ARCH_LEN'(4);
        end
      end else if (rsp_live) begin
        // Decode is holding a valid instruction; park the new one until the stall clears.
        skid_q  <= {1'b1, imem.imem_rsp_data};
        skid_pc <= req_pc + ARCH_LEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [32:0] fo;
  logic [31:0] pc_out;
  int          total;
  int          bad;
  logic [31:0] exp_addr;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem             (bus),
    .inst_fetched_out (fo),
    .pc_out           (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rsp_pulse(input logic [31:0] data);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    tick();
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(fo[32]), 64'(v));
    if (v) begin
      check({tag, "_inst"}, 64'(fo[31:0]), 64'(inst));
      check({tag, "_pc"}, 64'(pc_out), 64'(pc));
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
    check({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'(v));
    if (v) check({tag, "_req_addr"}, 64'(bus.imem_req_addr), 64'(addr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;

    @(negedge clk);
    tick();
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_out", 64'(fo), 64'd0);
    check("rst_pc_out", 64'(pc_out), 64'd0);
    rst = 1'b0;
    #1;
    chk_req("first", 1'b1, 32'h0000_1000);

    // straight line: one request every two cycles, 1-cycle response
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h0000_1000 + 32'(4 * i);
      chk_req("sl", 1'b1, exp_addr);
      tick();
      chk_req("sl_wait", 1'b0, 32'h0);
      rsp_pulse(32'hC0DE_0000 | exp_addr);
      chk_out("sl_out", 1'b1, 32'hC0DE_0000 | exp_addr, exp_addr + 32'd4);
    end

    // stall with skid
    stall = 1'b1;
    tick();
    chk_out("stall_a", 1'b1, 32'hC0DE_1008, 32'h0000_100C);
    rsp_pulse(32'hC0DE_100C);
    chk_out("skid_hold_a", 1'b1, 32'hC0DE_1008, 32'h0000_100C);
    chk_req("skid_full", 1'b0, 32'h0);
    tick();
    chk_out("skid_hold_a2", 1'b1, 32'hC0DE_1008, 32'h0000_100C);
    chk_req("skid_full2", 1'b0, 32'h0);
    stall = 1'b0;
    tick();
    chk_out("skid_b", 1'b1, 32'hC0DE_100C, 32'h0000_1010);
    chk_req("skid_resume", 1'b1, 32'h0000_1010);

    // redirect during WAIT
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_2002;
    tick();
    branch_taken = 1'b0;
    chk_req("drain", 1'b0, 32'h0);
    rsp_pulse(32'hDEAD_BEEF);
    chk_out("stale_drop", 1'b0, 32'h0, 32'h0);
    chk_req("post_drain", 1'b1, 32'h0000_2000);
    tick();
    rsp_pulse(32'hC0DE_2000);
    chk_out("redir_out", 1'b1, 32'hC0DE_2000, 32'h0000_2004);

    // redirect concurrent with response and stall
    stall = 1'b1;
    tick();
    chk_out("pre_redir_hold", 1'b1, 32'hC0DE_2000, 32'h0000_2004);
    branch_taken = 1'b1; branch_target = 32'h0000_3000;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    branch_taken = 1'b0; bus.imem_rsp_valid = 1'b0; stall = 1'b0;
    chk_out("redir_rsp_stall", 1'b0, 32'h0, 32'h0);
    chk_req("redir_rsp_stall", 1'b1, 32'h0000_3000);

    // backpressure then wrap
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("bp", 1'b1, 32'h0000_3000);
    end
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    chk_req("wrap_pc", 1'b1, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    tick();
    chk_req("wrap_wait", 1'b0, 32'h0);
    rsp_pulse(32'hC0DE_FFFC);
    chk_out("wrap_out", 1'b1, 32'hC0DE_FFFC, 32'h0000_0000);
    chk_req("wrap_next", 1'b1, 32'h0000_0000);

    // redirect in REQ with the request accepted the same cycle
    branch_taken = 1'b1; branch_target = 32'h0000_4000;
    tick();
    branch_taken = 1'b0;
    chk_req("redir_acc_drain", 1'b0, 32'h0);
    chk_out("redir_acc_out", 1'b0, 32'h0, 32'h0);
    rsp_pulse(32'hDEAD_0000);
    chk_req("redir_acc_next", 1'b1, 32'h0000_4000);

    // reset while a request is outstanding
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1A7E_1A7E;
    #1;
    chk_req("post_rst", 1'b1, 32'h0000_1000);
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("late_rsp_out", 64'(fo), 64'd0);
    check("late_rsp_pc", 64'(pc_out), 64'd0);
    rsp_pulse(32'hC0DE_1000);
    chk_out("post_rst_out", 1'b1, 32'hC0DE_1000, 32'h0000_1004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
